// File: rtl/prog_loader_rx_pkg.sv
// Shared encodings and constants for the serial program loader.
// The byte receiver and the image loader both import this package.
package prog_loader_rx_pkg;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  typedef enum logic [2:0] {
    LD_LEN,
    LD_LOAD,
    LD_PAD,
    LD_LINE_WR,
    LD_DONE
  } ld_state_t;

  localparam int LEN_BYTES  = 4;
  localparam int LINE_BYTES = 16;

  // Place byte b into lane pos of a little-endian 32-bit word.
  function automatic logic [31:0] insert_byte(input logic [31:0] w,
                                              input logic [1:0]  pos,
                                              input logic [7:0]  b);
    logic [31:0] r;
    r = w;
    r[{pos, 3'b000} +: 8] = b;
    return r;
  endfunction

endpackage

// File: rtl/prog_loader_rx_uart_rx_byte.sv
// UART 8N1 byte receiver: 2-flop synchronizer, start-bit qualification,
// mid-bit sampling and stop-bit check with a one-cycle byte_valid strobe.
module uart_rx_byte
  import prog_loader_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rxd,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);

  logic [1:0]    sync;
  logic          rx;
  logic          rx_prev;
  rx_state_t     state;
  rx_state_t     state_next;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          brk;
  logic          tick_half;
  logic          tick_full;
  logic          stop_sample;

  assign rx          = sync[1];
  assign tick_half   = (cnt == HALF);
  assign tick_full   = (cnt == FULL);
  assign stop_sample = (state == RX_STOP) && !brk && tick_full;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= RX_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      RX_IDLE:  if (rx_prev && !rx) state_next = RX_START;
      RX_START: if (tick_half) state_next = rx ? RX_IDLE : RX_DATA;
      RX_DATA:  if (tick_full && bit_idx == 3'd7) state_next = RX_STOP;
      // After a bad stop bit, hold here until the line returns high.
      RX_STOP:  if ((brk || tick_full) && rx) state_next = RX_IDLE;
      default:  state_next = RX_IDLE;
    endcase
  end

  always_comb begin
    byte_valid = stop_sample && rx;
    frame_err  = stop_sample && !rx;
    byte_data  = shreg;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync    <= 2'b11;
      rx_prev <= 1'b1;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      brk     <= 1'b0;
    end else begin
      sync    <= {sync[0], rxd};
      rx_prev <= rx;
      if (state_next != state || (state == RX_DATA && tick_full)) cnt <= '0;
      else cnt <= cnt + 1'b1;
      if (state == RX_START) bit_idx <= '0;
      if (state == RX_DATA && tick_full) begin
        shreg   <= {rx, shreg[7:1]};
        bit_idx <= bit_idx + 1'b1;
      end
      if (frame_err) brk <= 1'b1;
      else if (state_next == RX_IDLE) brk <= 1'b0;
    end
  end

endmodule

// File: rtl/prog_loader_rx.sv
// Serial program loader: decodes a length-prefixed UART image into 32-bit
// data-memory writes and 128-bit instruction-line writes.
module prog_loader_rx
  import prog_loader_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int ADDR_LEN     = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                rxd,
  output logic [ADDR_LEN-1:0] addr,
  output logic [127:0]        data,
  output logic                we_32,
  output logic                we_128,
  output logic                done,
  output logic                err
);

  localparam logic [1:0]          LEN_LAST  = 2'(LEN_BYTES - 1);
  localparam logic [1:0]          WORD_LAST = 2'(LINE_BYTES / 4 - 1);
  localparam logic [ADDR_LEN-1:0] LINE_OFS  = ADDR_LEN'(LINE_BYTES - 4);
  localparam logic [ADDR_LEN-1:0] WORD_STEP = ADDR_LEN'(4);

  logic                byte_valid;
  logic [7:0]          byte_data;
  logic                frame_err;
  ld_state_t           state;
  ld_state_t           state_next;
  logic [31:0]         len;
  logic [31:0]         len_next;
  logic [1:0]          len_idx;
  logic [31:0]         count;
  logic [31:0]         word_buf;
  logic [31:0]         new_word;
  logic [1:0]          byte_pos;
  logic [1:0]          word_idx;
  logic [ADDR_LEN-1:0] word_addr;
  logic                last_byte;
  logic                accept_len;
  logic                accept_byte;
  logic                emit_word;
  logic                shift_pad;
  logic                line_wr;

  uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk        (clk),
    .reset      (reset),
    .rxd        (rxd),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .frame_err  (frame_err)
  );

  assign len_next  = {byte_data, len[31:8]};
  assign new_word  = insert_byte(word_buf, byte_pos, byte_data);
  assign last_byte = (count + 32'd1 == len);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= LD_LEN;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      LD_LEN:
        if (byte_valid && len_idx == LEN_LAST)
          state_next = (len_next == '0) ? LD_DONE : LD_LOAD;
      LD_LOAD:
        if (byte_valid && (byte_pos == 2'd3 || last_byte)) begin
          if (word_idx == WORD_LAST) state_next = LD_LINE_WR;
          else if (last_byte)        state_next = LD_PAD;
        end
      LD_PAD:     if (word_idx == WORD_LAST) state_next = LD_LINE_WR;
      LD_LINE_WR: state_next = (count == len) ? LD_DONE : LD_LOAD;
      LD_DONE:    state_next = LD_DONE;
      default:    state_next = LD_LEN;
    endcase
  end

  always_comb begin
    accept_len  = (state == LD_LEN) && byte_valid;
    accept_byte = (state == LD_LOAD) && byte_valid;
    emit_word   = accept_byte && (byte_pos == 2'd3 || last_byte);
    shift_pad   = (state == LD_PAD);
    line_wr     = (state == LD_LINE_WR);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr      <= '0;
      data      <= '0;
      we_32     <= 1'b0;
      we_128    <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      len       <= '0;
      len_idx   <= '0;
      count     <= '0;
      word_buf  <= '0;
      byte_pos  <= '0;
      word_idx  <= '0;
      word_addr <= '0;
    end else begin
      we_32  <= emit_word;
      we_128 <= line_wr;
      if (frame_err && state != LD_DONE) err <= 1'b1;
      if (accept_len) begin
        len     <= len_next;
        len_idx <= len_idx + 1'b1;
        if (len_idx == LEN_LAST && len_next == '0) done <= 1'b1;
      end
      if (accept_byte) begin
        count <= count + 32'd1;
        if (emit_word) begin
          word_buf <= '0;
          byte_pos <= '0;
          data     <= {new_word, data[127:32]};
          addr     <= word_addr;
          word_idx <= word_idx + 1'b1;
          if (word_idx != WORD_LAST) word_addr <= word_addr + WORD_STEP;
        end else begin
          word_buf <= new_word;
          byte_pos <= byte_pos + 1'b1;
        end
      end
      // Zero words complete a partial line; no data-memory write for them.
      if (shift_pad) begin
        data     <= {32'd0, data[127:32]};
        word_idx <= word_idx + 1'b1;
        if (word_idx != WORD_LAST) word_addr <= word_addr + WORD_STEP;
      end
      if (line_wr) begin
        addr      <= word_addr - LINE_OFS;
        word_addr <= word_addr + WORD_STEP;
      end
      if (state == LD_DONE) done <= 1'b1;
    end
  end

endmodule

// File: tb/tb_prog_loader_rx.sv
// Directed bench for prog_loader_rx: drives UART frames and scoreboards the
// expected memory writes against the write-enable pulses.
module tb_prog_loader_rx;

  localparam int CPB = 4;

  typedef struct {
    bit           is128;
    logic [31:0]  addr;
    logic [127:0] data;
  } wr_t;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         rxd = 1'b1;
  logic [31:0]  addr;
  logic [127:0] data;
  logic         we_32;
  logic         we_128;
  logic         done;
  logic         err;

  int  tests = 0;
  int  fails = 0;
  int  cyc = 0;
  int  last128_cyc = -100;
  int  done_cyc = -200;
  bit  done_q = 1'b0;
  wr_t sb[$];
  wr_t e;

  prog_loader_rx #(.CLKS_PER_BIT(CPB), .ADDR_LEN(32)) dut (
    .clk    (clk),
    .reset  (reset),
    .rxd    (rxd),
    .addr   (addr),
    .data   (data),
    .we_32  (we_32),
    .we_128 (we_128),
    .done   (done),
    .err    (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard side: every write pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (!reset) begin
      if (we_32 && we_128) check("we_overlap", 1'b1, 1'b0);
      if (we_32 || we_128) begin
        if (sb.size() == 0) begin
          check("unexpected_write", {addr, 2'b00, we_128, we_32}, '0);
        end else begin
          e = sb.pop_front();
          check("write_kind", we_128, e.is128);
          check("write_addr", addr, e.addr);
          if (we_128) check("we128_data", data, e.data);
          else        check("we32_data", data[127:96], e.data[31:0]);
        end
      end
      if (we_128) last128_cyc = cyc;
      if (done && !done_q) done_cyc = cyc;
      done_q = done;
    end else begin
      done_q = 1'b0;
    end
  end

  initial begin
    #(60000 * 10);
    $display("FAIL watchdog: time limit reached before end of test sequence");
    $fatal(1, "timeout");
  end

  task automatic push32(input logic [31:0] a, input logic [31:0] w);
    wr_t x;
    x.is128 = 1'b0; x.addr = a; x.data = {96'd0, w};
    sb.push_back(x);
  endtask

  task automatic push128(input logic [31:0] a, input logic [127:0] d);
    wr_t x;
    x.is128 = 1'b1; x.addr = a; x.data = d;
    sb.push_back(x);
  endtask

  task automatic send_bit(input logic v);
    rxd = v;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop, input int gap);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop);
    for (int i = 0; i < gap; i++) send_bit(1'b1);
  endtask

  task automatic send_len(input logic [31:0] n, input int gap);
    for (int i = 0; i < 4; i++) send_byte(n[8*i +: 8], 1'b1, gap);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_addr"}, addr, '0);
    check({tag, "_data"}, data, '0);
    check({tag, "_we"}, {we_128, we_32}, '0);
    check({tag, "_done_err"}, {done, err}, '0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    rxd   = 1'b1;
    #1;
    check_zero_outputs("reset");
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    sb.delete();
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && !done; i++) @(negedge clk);
    check("done", done, 1'b1);
    repeat (4) @(negedge clk);
    check("sb_empty", sb.size(), 0);
  endtask

  initial begin
    logic [7:0]   b2[32];
    logic [31:0]  w;
    logic [127:0] line;

    // Full line
    do_reset();
    push32(32'd0,  32'h03020100);
    push32(32'd4,  32'h07060504);
    push32(32'd8,  32'h0B0A0908);
    push32(32'd12, 32'h0F0E0D0C);
    push128(32'd0, 128'h0F0E0D0C_0B0A0908_07060504_03020100);
    send_len(32'd16, 1);
    for (int i = 0; i < 16; i++) send_byte(8'(i), 1'b1, 1);
    wait_done(200);
    check("full_done_timing", done_cyc - last128_cyc, 1);
    check("full_err", err, 1'b0);

    // Tail padding
    do_reset();
    push32(32'd0, 32'hDDCCBBAA);
    push32(32'd4, 32'h000000EE);
    push128(32'd0, 128'h00000000_00000000_000000EE_DDCCBBAA);
    send_len(32'd5, 1);
    send_byte(8'hAA, 1'b1, 1);
    send_byte(8'hBB, 1'b1, 1);
    send_byte(8'hCC, 1'b1, 1);
    send_byte(8'hDD, 1'b1, 1);
    send_byte(8'hEE, 1'b1, 1);
    wait_done(200);
    check("tail_done_timing", done_cyc - last128_cyc, 1);

    // Empty image
    do_reset();
    for (int i = 0; i < 3; i++) send_byte(8'h00, 1'b1, 1);
    check("empty_not_done_early", done, 1'b0);
    send_byte(8'h00, 1'b1, 0);
    wait_done(8);
    check("empty_err", err, 1'b0);

    // Framing error
    do_reset();
    push32(32'd0, 32'h44332211);
    push128(32'd0, 128'h00000000_00000000_00000000_44332211);
    send_len(32'd4, 1);
    send_byte(8'h5A, 1'b0, 2);
    check("err_sticky", err, 1'b1);
    send_byte(8'h11, 1'b1, 1);
    send_byte(8'h22, 1'b1, 1);
    send_byte(8'h33, 1'b1, 1);
    send_byte(8'h44, 1'b1, 1);
    wait_done(200);
    check("frame_err_final", err, 1'b1);

    // Reset mid-stream during payload byte 7
    do_reset();
    push32(32'd0, 32'h03020100);
    send_len(32'd16, 1);
    for (int i = 0; i < 7; i++) send_byte(8'(i), 1'b1, 1);
    check("mid_sb_drained", sb.size(), 0);
    check("mid_data_loaded", data[127:96], 32'h03020100);
    rxd = 1'b0;
    repeat (6) @(negedge clk);
    #3 reset = 1'b1;
    #1 check_zero_outputs("mid_reset");
    rxd = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (2 * CPB) @(negedge clk);
    push32(32'd0, 32'h44332211);
    push128(32'd0, 128'h00000000_00000000_00000000_44332211);
    send_len(32'd4, 1);
    send_byte(8'h11, 1'b1, 1);
    send_byte(8'h22, 1'b1, 1);
    send_byte(8'h33, 1'b1, 1);
    send_byte(8'h44, 1'b1, 1);
    wait_done(200);

    // Back-to-back two-line image
    do_reset();
    for (int i = 0; i < 32; i++) b2[i] = 8'(i * 7 + 5);
    for (int l = 0; l < 2; l++) begin
      line = '0;
      for (int k = 0; k < 4; k++) begin
        w = {b2[16*l + 4*k + 3], b2[16*l + 4*k + 2], b2[16*l + 4*k + 1], b2[16*l + 4*k]};
        push32(32'(16*l + 4*k), w);
        line[32*k +: 32] = w;
      end
      push128(32'(16*l), line);
    end
    send_len(32'd32, 0);
    for (int i = 0; i < 32; i++) send_byte(b2[i], 1'b1, 0);
    rxd = 1'b1;
    wait_done(200);
    check("b2b_done_timing", done_cyc - last128_cyc, 1);
    check("b2b_err", err, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/prog_loader_rx.md
# prog_loader_rx

Serial program loader. Receives a UART 8N1 byte stream on `rxd`, decodes a length-prefixed image, and drives the instruction- and data-memory load port: 32-bit data-memory writes and 128-bit instruction-line writes. It sits between the board RXD pin and the top-level `prog_load*` / memory mux, and asserts `done` when the image is complete. It is the receiving end of the host download link; the core's UART transmitter is the other direction of the same link.

## Interface
- `CLKS_PER_BIT`, 868: `clk` cycles per UART bit. Must be ≥ 4.
- `ADDR_LEN`, 32: width of `addr`.
- `clk`  in  1  single clock; all logic is rising-edge.
- `reset`  in  1  asynchronous, active-high. Clears all state.
- `rxd`  in  1  UART receive line, idle high, asynchronous to `clk`.
- `addr`  out  ADDR_LEN  byte address of the current write.
- `data`  out  128  load data. The newest word is in [127:96]; a full line holds word0 in [31:0].
- `we_32`  out  1  one-cycle pulse: write `data[127:96]` to data memory at `addr`.
- `we_128`  out  1  one-cycle pulse: write `data` to instruction memory at line `addr`.
- `done`  out  1  sticky. Image fully written.
- `err`  out  1  sticky. Framing error seen.

## Operation
- **Reset values.** All outputs are 0. Both state machines are in their first state, and the byte counter and word address are 0.
- **Input sync.** `rxd` passes through a 2-flop synchronizer that resets to 1.
- **Byte receiver FSM.**
  - IDLE: on a synchronized falling edge, go to START.
  - START: at CLKS_PER_BIT/2, resample. If the line is low, go to DATA; if high, treat it as a glitch and return to IDLE.
  - DATA: sample 8 bits, LSB first, each CLKS_PER_BIT apart, then go to STOP.
  - STOP: sample once. If 1, emit a one-cycle `byte_valid`. If 0, set `err`, discard the byte, and wait for `rxd`=1 before returning to IDLE.
- **Loader FSM.**
  - LEN: the first 4 valid bytes form N (32-bit, little-endian). If N=0, go to DONE; otherwise go to LOAD.
  - LOAD: each payload byte fills the word little-endian (byte0 goes to bits [7:0]).
  - On each completed word:
    - shift `data` right: `data <= {word, data[127:32]}`;
    - pulse `we_32` with `addr` = word byte address (0, 4, 8, …);
    - if this is the 4th word of the line, go to LINE_WR.
  - LINE_WR: one cycle. Pulse `we_128` with `addr` = line base (word address − 12), advance the word address, then return to LOAD, or to DONE if N bytes have been consumed.
  - DONE: `done`=1 and further `rxd` activity is ignored until reset.
- **Tail handling** when N is not a multiple of 16:
  - A partial final word is zero-padded in its high bytes and written with `we_32`.
  - A partial line is then completed by shifting in zero words, one per cycle, with no `we_32`.
  - This is followed by LINE_WR and DONE.
- **Framing errors.** `err` does not abort loading; the bad byte is simply missing from the stream.
- **Address arithmetic.** The word address is modulo 2^ADDR_LEN; wraparound is not flagged.

## Timing
- `rxd` to internal sample latency: 2 cycles (synchronizer).
- A stop-bit sample produces `byte_valid` in the same cycle.
- `we_32` asserts the cycle after the byte that completes a word.
- `we_128` asserts exactly 1 cycle after the 4th `we_32` of a line. `we_32` and `we_128` are never high together.
- `addr` and `data` are stable during every write-enable pulse.
- `done` rises the cycle after the final `we_128`, or the cycle after the 4th length byte when N=0.
- Back-to-back UART bytes with no idle time between frames must be accepted; the loader consumes a byte in ≤ 2 cycles.
- `reset` asserted mid-frame or mid-line:
  - immediately zeroes all outputs;
  - any partial line is lost;
  - after release, the next falling edge is treated as a new length byte.

## Structure
- A shared package holds:
  - byte FSM state encoding {IDLE, START, DATA, STOP};
  - loader FSM state encoding {LEN, LOAD, PAD, LINE_WR, DONE};
  - the length-field byte count (4);
  - the line size (16 bytes).
- One sub-module, `uart_rx_byte`: synchronizer plus byte FSM, with outputs `byte_valid`, `byte_data[7:0]`, `frame_err`. The loader FSM stays in the top module.

## Test plan
All scenarios use CLKS_PER_BIT=4.
- **Full line.** Send N=16, then bytes 0x00..0x0F.
  - Expect 4 `we_32` pulses at addr 0/4/8/12 with `data[127:96]` = 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C.
  - Then `we_128` at addr 0 with data = 0x0F0E0D0C_0B0A0908_07060504_03020100, then `done`.
- **Tail padding.** Send N=5, bytes AA BB CC DD EE.
  - Expect `we_32` 0xDDCCBBAA @0, then `we_32` 0x000000EE @4.
  - Then `we_128` @0 with data = 0x00000000_00000000_000000EE_DDCCBBAA, then `done`.
- **Empty image.** Send N=0 → `done` one cycle after the 4th length byte; no write-enable pulses.
- **Framing error.** Send N=4, then a byte with stop bit 0, then 11 22 33 44.
  - Expect `err`=1 and a single `we_32` 0x44332211 @0.
- **Reset mid-stream.** Assert `reset` during payload byte 7 of N=16.
  - Expect all outputs 0 immediately.
  - A fresh N=4 image then writes @0.
- **Back-to-back two-line image.** Send N=32 with no idle gaps.
  - Expect 8 `we_32` pulses, `we_128` at 0 and 16, no dropped bytes, and `err`=0.
